nn_program_sequencer: RTL
=========================

Name: nn_program_sequencer

Overview:
- Parametrised successor to the single-shot training controller.
- Fetches a program of opcodes from code memory by index, decodes each one, and drives the weight-load, forward, backprop and update strobes of the layer datapath.
- Per-layer sequencing, row counting and datapath done-handshakes are handled internally.
- Sits between the host/program ROM and the layer array.

Parameters:
OP_SIZE, 4, opcode width
ARG_W, 8, opcode argument width
NUM_LAYERS, 4, layers in network (>=1)
ROWS, 3, weight rows per layer (>=1)
CODE_W, 32, code index/count width
LAYER_W, $clog2(NUM_LAYERS) min 1, layer index width
ROW_W, $clog2(ROWS) min 1, row index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low; all state and outputs cleared while low
start  in  1  1-cycle pulse, begin program
code_count  in  CODE_W  program length; sampled on accepted start
op  in  OP_SIZE  code memory data; valid 1 cycle after code_index
op_arg  in  ARG_W  code memory argument, same timing as op
layer_done  in  1  datapath finished current layer step
code_index  out  CODE_W  code memory address
code_active  out  1  program executing
code_reset  out  1  1-cycle pulse at program end
w_layer_index  out  LAYER_W  current layer
w_row_index  out  ROW_W  current weight row
load_w  out  1  write weight row
use_z  out  1  forward pass active
is_load  out  1  1-cycle pulse at start of each layer step
backprop_cost  out  1  cost-derivative injection
is_update  out  1  weight update active
err  out  1  sticky illegal opcode/argument

Behaviour:
- Reset: every output 0; FSM in IDLE; latched layer 0; cost mode 0.
- Opcodes: 0 NOP, 1 SET_LAYER, 2 SET_COST, 3 LOAD_W, 4 FORWARD, 5 BACKPROP, 6 UPDATE. 7 and above are illegal.
- States: IDLE, FETCH, DECODE, ROWS, LSTEP, LWAIT, DONE.
- IDLE:
  - start with code_count>0 -> FETCH; code_active=1; code_index=0.
  - start with code_count==0 -> DONE.
  - start while code_active=1 is ignored.
- FETCH: address is stable for one cycle -> DECODE, where op/op_arg are sampled.
- Single-cycle ops take 2 cycles total (FETCH+DECODE):
  - NOP: no action.
  - SET_LAYER: latched layer=op_arg. If op_arg>=NUM_LAYERS, set err and leave layer unchanged.
  - SET_COST: cost mode=op_arg[0].
- Illegal opcode: set err; execute as NOP.
- LOAD_W -> ROWS state:
  - ROWS consecutive cycles with load_w=1.
  - w_row_index runs 0..ROWS-1; w_layer_index = latched layer.
  - w_row_index returns to 0 after the last row.
- FORWARD, BACKPROP and UPDATE walk the layers:
  - FORWARD: ascending 0..NUM_LAYERS-1.
  - BACKPROP: descending NUM_LAYERS-1..0.
  - UPDATE: ascending.
  - Per layer: LSTEP (is_load pulse, w_layer_index=layer), then LWAIT until layer_done.
  - layer_done already high in LSTEP is ignored; only LWAIT samples it.
  - The cycle after layer_done: next layer's LSTEP, or end of instruction.
  - use_z, is_update, backprop: level=1 through LSTEP/LWAIT of their op.
  - backprop_cost=1 only while on layer NUM_LAYERS-1 of BACKPROP, and only if cost mode=1.
- End of instruction:
  - If code_index==code_count-1 -> DONE.
  - Otherwise code_index+1 -> FETCH.
- DONE: code_reset=1 for one cycle; code_index=0; code_active=0 -> IDLE.
- Arithmetic: code_index increments modulo 2^CODE_W; code_count=2^CODE_W-1 is legal.
- Reset asserted mid-instruction aborts immediately. There is no code_reset pulse. err is cleared only by reset.

Optional Feature:
NN_SEQ_EPOCH_EN
- With the macro: adds parameter EPOCH_W=16, input epochs[EPOCH_W], and output epoch_index[EPOCH_W].
  - epochs is sampled on start.
  - At the end of the program, if epoch_index<epochs-1: increment epoch_index, pulse code_reset, set code_index=0, go to FETCH with code_active held at 1.
  - Otherwise go to DONE.
  - epochs==0 is treated as 1.
- Without the macro: a single pass; no extra ports.

Decomposition:
- Package nn_seq_pkg holds:
  - opcode localparams OP_NOP..OP_UPDATE;
  - the FSM state enum typedef;
  - a function is_layer_op(op).
- One sub-module, nn_layer_walker: the layer counter with ascending/descending direction, and the LSTEP/LWAIT handshake producing is_load and last_layer.
- The top module keeps fetch/decode, the row counter and the strobe muxing.

Test Plan:
1. Reset low mid-LOAD_W (row 1) -> all outputs 0 next edge.
   - Release reset, then start -> code_index=0, code_active=1.
2. Program [SET_LAYER 2, LOAD_W], code_count=2, ROWS=3 -> load_w high 3 cycles with w_row_index 0,1,2 and w_layer_index=2.
   - Then code_reset pulses once; code_active falls.
3. Program [SET_COST 1, BACKPROP], NUM_LAYERS=4, layer_done 2 cycles after each is_load:
   - w_layer_index 3,2,1,0;
   - backprop_cost=1 only during layer 3;
   - 4 is_load pulses.
4. FORWARD with layer_done held high from LSTEP -> each layer still takes LSTEP+1 LWAIT cycle; use_z high 8 cycles total.
5. Edge cases:
   - start with code_count=0 -> code_reset pulse, no strobes.
   - op=9 -> err=1, program continues.
   - SET_LAYER 7 -> err=1, layer unchanged.
6. NN_SEQ_EPOCH_EN, epochs=3, 1-op program -> code_reset pulses 3 times; epoch_index 0,1,2; code_active continuous until final DONE.

Source files
------------

// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: opcode encodings, sequencer FSM states and decode helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nn_seq_pkg;

  localparam int OP_NOP       = 0;
  localparam int OP_SET_LAYER = 1;
  localparam int OP_SET_COST  = 2;
  localparam int OP_LOAD_W    = 3;
  localparam int OP_FORWARD   = 4;
  localparam int OP_BACKPROP  = 5;
  localparam int OP_UPDATE    = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ROWS,
    S_LSTEP,
    S_LWAIT,
    S_DONE
  } seq_state_e;

  // Opcodes that walk every layer of the network with a per-layer handshake.
  function automatic logic is_layer_op(input int op);
    return (op == OP_FORWARD) || (op == OP_BACKPROP) || (op == OP_UPDATE);
  endfunction

endpackage

// File: rtl/nn_layer_walker.sv
// nn_layer_walker: layer counter (ascending or descending) plus LSTEP/LWAIT handshake.
// Latency: layer advances on the edge that accepts layer_done_i in LWAIT.
// Backpressure: holds the current layer until the datapath raises layer_done_i in LWAIT.
// Ports: load_i/desc_i arm the walk, lstep_i/lwait_i give the parent's phase,
//        layer_o/is_load_o/last_o/adv_o report position and step completion.
module nn_layer_walker #(
  parameter int NUM_LAYERS = 4,
  parameter int LAYER_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               desc_i,
  input  logic               lstep_i,
  input  logic               lwait_i,
  input  logic               layer_done_i,
  output logic [LAYER_W-1:0] layer_o,
  output logic               is_load_o,
  output logic               last_o,
  output logic               adv_o
);

  localparam logic [LAYER_W-1:0] TOP = LAYER_W'(NUM_LAYERS - 1);

  logic [LAYER_W-1:0] layer_q, layer_d;
  logic               desc_q, desc_d;

  assign layer_o   = layer_q;
  assign is_load_o = lstep_i;
  // layer_done is deliberately ignored during LSTEP; only LWAIT consumes it.
  assign adv_o     = lwait_i & layer_done_i;
  assign last_o    = desc_q ? (layer_q == '0) : (layer_q == TOP);

  always_comb begin
    layer_d = layer_q;
    desc_d  = desc_q;
    if (load_i) begin
      desc_d  = desc_i;
      layer_d = desc_i ? TOP : '0;
    end else if (adv_o && !last_o) begin
      layer_d = desc_q ? layer_q - LAYER_W'(1) : layer_q + LAYER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer_q <= '0;
      desc_q  <= 1'b0;
    end else begin
      layer_q <= layer_d;
      desc_q  <= desc_d;
    end
  end

endmodule

// File: rtl/nn_program_sequencer.sv
// nn_program_sequencer: fetches/decodes opcodes and drives layer-datapath strobes.
// Latency: 2 cycles per single-cycle op; LOAD_W 2+ROWS; layer ops 2 + per-layer handshake.
// Backpressure: layer ops stall in LWAIT until layer_done; code memory is never stalled.
// Ports: start/code_count begin a program; code_index/op/op_arg form the code-memory
//        read port; load_w/use_z/is_load/backprop_cost/is_update and the layer/row
//        indices drive the datapath; code_active/code_reset/err report status.
// Optional: define NN_SEQ_EPOCH_EN to add epochs/epoch_index and repeat the program.
module nn_program_sequencer
  import nn_seq_pkg::*;
#(
  parameter int OP_SIZE    = 4,
  parameter int ARG_W      = 8,
  parameter int NUM_LAYERS = 4,
  parameter int ROWS       = 3,
  parameter int CODE_W     = 32,
  parameter int LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  parameter int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1
`ifdef NN_SEQ_EPOCH_EN
  ,
  parameter int EPOCH_W    = 16
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CODE_W-1:0]  code_count,
  input  logic [OP_SIZE-1:0] op,
  input  logic [ARG_W-1:0]   op_arg,
  input  logic               layer_done,
`ifdef NN_SEQ_EPOCH_EN
  input  logic [EPOCH_W-1:0] epochs,
  output logic [EPOCH_W-1:0] epoch_index,
`endif
  output logic [CODE_W-1:0]  code_index,
  output logic               code_active,
  output logic               code_reset,
  output logic [LAYER_W-1:0] w_layer_index,
  output logic [ROW_W-1:0]   w_row_index,
  output logic               load_w,
  output logic               use_z,
  output logic               is_load,
  output logic               backprop_cost,
  output logic               is_update,
  output logic               err
);

  seq_state_e         state_q, state_d;
  logic [CODE_W-1:0]  idx_q, idx_d, count_q, count_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [OP_SIZE-1:0] opk_q, opk_d;
  logic               cost_q, cost_d, err_q, err_d, code_reset_q, code_reset_d;
  logic               end_instr, walk_load, walk_last, walk_adv, in_walk;
  logic [LAYER_W-1:0] walk_layer;
`ifdef NN_SEQ_EPOCH_EN
  logic [EPOCH_W-1:0] epoch_q, epoch_d, epoch_last_q, epoch_last_d;
`endif

  nn_layer_walker #(
    .NUM_LAYERS(NUM_LAYERS),
    .LAYER_W   (LAYER_W)
  ) u_walker (
    .clk         (clk),
    .rst_n       (reset),
    .load_i      (walk_load),
    .desc_i      (int'(op) == OP_BACKPROP),
    .lstep_i     (state_q == S_LSTEP),
    .lwait_i     (state_q == S_LWAIT),
    .layer_done_i(layer_done),
    .layer_o     (walk_layer),
    .is_load_o   (is_load),
    .last_o      (walk_last),
    .adv_o       (walk_adv)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    layer_d      = layer_q;
    row_d        = row_q;
    opk_d        = opk_q;
    cost_d       = cost_q;
    err_d        = err_q;
    code_reset_d = 1'b0;
    walk_load    = 1'b0;
    end_instr    = 1'b0;
`ifdef NN_SEQ_EPOCH_EN
    epoch_d      = epoch_q;
    epoch_last_d = epoch_last_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        count_d = code_count;
        idx_d   = '0;
`ifdef NN_SEQ_EPOCH_EN
        epoch_d      = '0;
        // Zero epochs behaves as a single pass.
        epoch_last_d = (epochs == '0) ? '0 : epochs - EPOCH_W'(1);
`endif
        if (code_count == '0) begin
          state_d      = S_DONE;
          code_reset_d = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        opk_d = op;
        if (is_layer_op(int'(op))) begin
          walk_load = 1'b1;
          state_d   = S_LSTEP;
        end else if (int'(op) == OP_LOAD_W) begin
          row_d   = '0;
          state_d = S_ROWS;
        end else begin
          end_instr = 1'b1;
          if (int'(op) == OP_SET_LAYER) begin
            if (int'(op_arg) >= NUM_LAYERS) err_d = 1'b1;
            else                            layer_d = LAYER_W'(op_arg);
          end else if (int'(op) == OP_SET_COST) begin
            cost_d = op_arg[0];
          end else if (int'(op) > OP_UPDATE) begin
            err_d = 1'b1;  // illegal opcode then falls through as a NOP
          end
        end
      end
      S_ROWS: begin
        if (row_q == ROW_W'(ROWS - 1)) begin
          row_d     = '0;
          end_instr = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      S_LSTEP: state_d = S_LWAIT;
      S_LWAIT: if (walk_adv) begin
        if (walk_last) end_instr = 1'b1;
        else           state_d   = S_LSTEP;
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (end_instr) begin
      if (idx_q == count_q - CODE_W'(1)) begin
        idx_d        = '0;
        code_reset_d = 1'b1;
        state_d      = S_DONE;
`ifdef NN_SEQ_EPOCH_EN
        // Another epoch remains: restart at index 0 without dropping code_active.
        if (epoch_q != epoch_last_q) begin
          epoch_d = epoch_q + EPOCH_W'(1);
          state_d = S_FETCH;
        end
`endif
      end else begin
        idx_d   = idx_q + CODE_W'(1);
        state_d = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      layer_q      <= '0;
      row_q        <= '0;
      opk_q        <= '0;
      cost_q       <= 1'b0;
      err_q        <= 1'b0;
      code_reset_q <= 1'b0;
`ifdef NN_SEQ_EPOCH_EN
      epoch_q      <= '0;
      epoch_last_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      layer_q      <= layer_d;
      row_q        <= row_d;
      opk_q        <= opk_d;
      cost_q       <= cost_d;
      err_q        <= err_d;
      code_reset_q <= code_reset_d;
`ifdef NN_SEQ_EPOCH_EN
      epoch_q      <= epoch_d;
      epoch_last_q <= epoch_last_d;
`endif
    end
  end

  assign in_walk       = (state_q == S_LSTEP) || (state_q == S_LWAIT);
  assign code_index    = idx_q;
  assign code_active   = (state_q != S_IDLE) && (state_q != S_DONE);
  assign code_reset    = code_reset_q;
  assign w_layer_index = in_walk ? walk_layer : layer_q;
  assign w_row_index   = row_q;
  assign load_w        = (state_q == S_ROWS);
  assign use_z         = in_walk && (int'(opk_q) == OP_FORWARD);
  assign is_update     = in_walk && (int'(opk_q) == OP_UPDATE);
  assign backprop_cost = in_walk && (int'(opk_q) == OP_BACKPROP) && cost_q &&
                         (walk_layer == LAYER_W'(NUM_LAYERS - 1));
  assign err           = err_q;
`ifdef NN_SEQ_EPOCH_EN
  assign epoch_index   = epoch_q;
`endif

endmodule
